// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron predictor: FSM state codes, derived
// widths, default training threshold and saturating weight arithmetic.
package perceptron_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SUM      = 3'd1;
  localparam logic [2:0] ST_WAIT_RES = 3'd2;
  localparam logic [2:0] ST_TRAIN    = 3'd3;
  localparam logic [2:0] ST_UPD      = 3'd4;

  // Widest weight supported; narrower weights are sign-extended into this.
  localparam int W_MAX_BITS = 8;

  function automatic int sum_width(input int w_bits, input int hist_len);
    return w_bits + $clog2(hist_len + 1) + 1;
  endfunction

  // floor(1.93 * hist_len + 14) in integer arithmetic
  function automatic int default_theta(input int hist_len);
    return (193 * hist_len + 1400) / 100;
  endfunction

  function automatic logic signed [7:0] sat_inc(input logic signed [7:0] w, input int w_bits);
    logic signed [7:0] w_max;
    w_max = 8'sd127 >>> (W_MAX_BITS - w_bits);
    return (w >= w_max) ? w_max : w + 8'sd1;
  endfunction

  function automatic logic signed [7:0] sat_dec(input logic signed [7:0] w, input int w_bits);
    logic signed [7:0] w_min;
    w_min = -8'sd128 >>> (W_MAX_BITS - w_bits);
    return (w <= w_min) ? w_min : w - 8'sd1;
  endfunction

endpackage

// File: rtl/perceptron_weight_ram.sv
// Weight storage: DEPTH x W_BITS register array, asynchronous read, one
// synchronous write port, every entry cleared while rst_n is low.
module perceptron_weight_ram #(
  parameter int DEPTH  = 128,
  parameter int W_BITS = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            addr,
  input  logic signed [W_BITS-1:0] wdata,
  output logic signed [W_BITS-1:0] rdata
);
  logic signed [W_BITS-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  assign rdata = mem_reg[addr];

endmodule

// File: rtl/perceptron_predictor_core.sv
// Perceptron branch predictor core: serial bipolar dot product, prediction,
// saturating training and global-history shift. Optional PERC_STATS_EN adds counters.
module perceptron_predictor_core
  import perceptron_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int HIST_LEN  = 7,
  parameter int NUM_PERC  = 16,
  parameter int W_BITS    = 8,
  parameter int THETA     = default_theta(HIST_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  input  logic                 res_valid,
  input  logic                 res_taken,
  output logic                 upd_done
`ifdef PERC_STATS_EN
  ,
  output logic [15:0]          pred_ctr,
  output logic [15:0]          mispred_ctr
`endif
);
  localparam int IDX_W  = $clog2(NUM_PERC);
  localparam int SUM_W  = sum_width(W_BITS, HIST_LEN);
  localparam int SUM_XW = SUM_W + 1;
  localparam int CNT_W  = $clog2(HIST_LEN + 1);
  localparam int DEPTH  = NUM_PERC * (HIST_LEN + 1);
  localparam int AW     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HIST_LEN);

  logic [2:0]              state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [SUM_W-1:0] sum_reg;
  logic [HIST_LEN-1:0]     hist_reg;
  logic                    res_taken_reg;

  logic [AW-1:0]             ram_addr;
  logic signed [W_BITS-1:0]  w_rd;
  logic signed [W_BITS-1:0]  w_wr;
  logic                      ram_we;
  logic [HIST_LEN:0]         x_vec;
  logic                      x_bit;
  logic signed [SUM_W-1:0]   w_ext;
  logic signed [SUM_W-1:0]   term;
  logic signed [SUM_XW-1:0]  sum_x;
  logic [SUM_XW-1:0]         sum_mag;
  logic                      pred_dir;
  logic                      need_train;
  logic                      cnt_last_hit;
  logic signed [7:0]         w8;
  logic                      unused_pc;

  assign unused_pc = ^{req_pc[ADDR_BITS-1:IDX_W+2], req_pc[1:0]};

  assign ram_addr = AW'(idx_reg) * AW'(HIST_LEN + 1) + AW'(cnt_reg);
  assign ram_we   = (state_reg == ST_TRAIN);

  perceptron_weight_ram #(
    .DEPTH  (DEPTH),
    .W_BITS (W_BITS),
    .AW     (AW)
  ) u_weight_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (w_wr),
    .rdata (w_rd)
  );

  // Input vector: x0 is the constant bias input, xi is hist[i-1].
  assign x_vec        = {hist_reg, 1'b1};
  assign x_bit        = x_vec[cnt_reg];
  assign cnt_last_hit = (cnt_reg == CNT_LAST);

  assign w_ext = SUM_W'(w_rd);
  assign term  = x_bit ? w_ext : -w_ext;

  // One extra bit so negating the most-negative sum cannot overflow.
  assign sum_x      = SUM_XW'(sum_reg);
  assign sum_mag    = sum_x[SUM_XW-1] ? SUM_XW'(-sum_x) : SUM_XW'(sum_x);
  assign pred_dir   = ~sum_reg[SUM_W-1];
  assign need_train = (pred_dir != res_taken) || (sum_mag <= SUM_XW'(THETA));

  assign w8   = W_MAX_BITS'(w_rd);
  assign w_wr = (x_bit == res_taken_reg) ? W_BITS'(sat_inc(w8, W_BITS))
                                         : W_BITS'(sat_dec(w8, W_BITS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      hist_reg      <= '0;
      res_taken_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            idx_reg   <= req_pc[IDX_W+1:2];
            sum_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_SUM;
          end
        end
        ST_SUM: begin
          sum_reg <= sum_reg + term;
          if (cnt_last_hit) begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT_RES;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            res_taken_reg <= res_taken;
            cnt_reg       <= '0;
            state_reg     <= need_train ? ST_TRAIN : ST_UPD;
          end
        end
        ST_TRAIN: begin
          if (cnt_last_hit) begin
            cnt_reg   <= '0;
            state_reg <= ST_UPD;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_UPD: begin
          hist_reg  <= (hist_reg << 1) | HIST_LEN'(res_taken_reg);
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign pred_valid = (state_reg == ST_WAIT_RES);
  assign pred_taken = pred_valid & pred_dir;
  assign upd_done   = (state_reg == ST_UPD);

`ifdef PERC_STATS_EN
  logic        mispred_reg;
  logic [15:0] pred_ctr_reg;
  logic [15:0] mispred_ctr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispred_reg     <= 1'b0;
      pred_ctr_reg    <= '0;
      mispred_ctr_reg <= '0;
    end else begin
      if (state_reg == ST_WAIT_RES && res_valid) mispred_reg <= pred_dir ^ res_taken;
      if (state_reg == ST_UPD) begin
        if (pred_ctr_reg != 16'hFFFF) pred_ctr_reg <= pred_ctr_reg + 16'd1;
        if (mispred_reg && mispred_ctr_reg != 16'hFFFF) mispred_ctr_reg <= mispred_ctr_reg + 16'd1;
      end
    end
  end

  assign pred_ctr    = pred_ctr_reg;
  assign mispred_ctr = mispred_ctr_reg;
`endif

endmodule
